// File: rtl/window_gen_3x3_if.sv
// rtl/window_gen_3x3_if.sv - pixel-in / window-out bundle for window_gen_3x3
// master drives the pixel stream and sinks windows; slave is the window generator.
interface window_gen_3x3_if #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  in_sof;
  logic                  out_valid;
  logic [9*DATA_W-1:0]   win_flat;
  logic [ROW_W-1:0]      out_row;
  logic [COL_W-1:0]      out_col;
  logic                  frame_done;

  modport master (
    output in_valid, in_data, in_sof,
    input  out_valid, win_flat, out_row, out_col, frame_done
  );

  modport slave (
    input  in_valid, in_data, in_sof,
    output out_valid, win_flat, out_row, out_col, frame_done
  );
endinterface

// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - 3x3 sliding-window former over a raster pixel stream
// Optional WIN_FRAME_SYNC_EN: in_sof on an accepted pixel forces it to position (0,0).
module window_gen_3x3 #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input logic                clk,
  input logic                rst,
  window_gen_3x3_if.slave    bus
);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  logic [COL_W-1:0]    col_q, col_d, cur_col, out_col_q;
  logic [ROW_W-1:0]    row_q, row_d, cur_row, out_row_q;
  logic                last_col, last_row, emit;
  logic                out_valid_q, frame_done_q;
  logic [9*DATA_W-1:0] win_q, win_d;
  logic [DATA_W-1:0]   col_top, col_mid;

  // lb1 holds row r-1, lb2 row r-2; sr keeps columns c-2 (idx 0) and c-1 (idx 1) per window row
  logic [DATA_W-1:0]   lb1_q [IMG_W];
  logic [DATA_W-1:0]   lb2_q [IMG_W];
  logic [DATA_W-1:0]   sr_q  [3][2];

`ifdef WIN_FRAME_SYNC_EN
  always_comb begin
    cur_col = col_q;
    cur_row = row_q;
    if (bus.in_valid && bus.in_sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end
`else
  logic unused_sof;
  assign unused_sof = bus.in_sof;
  assign cur_col    = col_q;
  assign cur_row    = row_q;
`endif

  always_comb begin
    last_col = (cur_col == COL_W'(IMG_W - 1));
    last_row = (cur_row == ROW_W'(IMG_H - 1));
    col_d    = last_col ? '0 : cur_col + 1'b1;
    row_d    = cur_row;
    if (last_col) begin
      row_d = last_row ? '0 : cur_row + 1'b1;
    end
    emit    = bus.in_valid && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
    col_top = lb2_q[cur_col];
    col_mid = lb1_q[cur_col];
    win_d   = {sr_q[0][0], sr_q[0][1], col_top,
               sr_q[1][0], sr_q[1][1], col_mid,
               sr_q[2][0], sr_q[2][1], bus.in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      out_valid_q  <= emit;
      frame_done_q <= emit && last_col && last_row;
      if (bus.in_valid) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      if (emit) begin
        win_q     <= win_d;
        out_row_q <= cur_row - ROW_W'(2);
        out_col_q <= cur_col - COL_W'(2);
      end
    end
  end

  // Storage is never cleared: row gating guarantees stale lines are overwritten before use
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      lb2_q[cur_col] <= col_mid;
      lb1_q[cur_col] <= bus.in_data;
      sr_q[0][0]     <= sr_q[0][1];
      sr_q[1][0]     <= sr_q[1][1];
      sr_q[2][0]     <= sr_q[2][1];
      sr_q[0][1]     <= col_top;
      sr_q[1][1]     <= col_mid;
      sr_q[2][1]     <= bus.in_data;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.win_flat   = win_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb/tb_window_gen_3x3.sv - randomized self-checking bench for window_gen_3x3
// Reference keeps a 2-D image of the current frame and cuts windows from it directly.
module tb_window_gen_3x3;
  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef struct packed {
    logic [9*DW-1:0] flat;
    logic [1:0]      row;
    logic [1:0]      col;
    logic            fd;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  window_gen_3x3_if #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) bus ();
  window_gen_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  win_t          exp_q[$];
  win_t          obs_q[$];
  int            obs_at[$];
  int            total = 0;
  int            bad = 0;
  int            pix_cnt, stall_viol, m_r, m_c;
  logic [DW-1:0] img [H][W];

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    obs_at.delete();
    pix_cnt = 0;
    stall_viol = 0;
    m_r = 0;
    m_c = 0;
  endtask

  // One clock of stimulus; updates the image model and records what the DUT emitted
  task automatic send(input logic v, input logic [DW-1:0] d, input logic s);
    win_t w;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sof   = s;
    if (v) begin
`ifdef WIN_FRAME_SYNC_EN
      if (s) begin
        m_r = 0;
        m_c = 0;
      end
`endif
      img[m_r][m_c] = d;
      if (m_r >= 2 && m_c >= 2) begin
        for (int i = 0; i < 9; i++)
          w.flat[(8-i)*DW +: DW] = img[m_r-2+i/3][m_c-2+i%3];
        w.row = 2'(m_r - 2);
        w.col = 2'(m_c - 2);
        w.fd  = (m_r == H-1) && (m_c == W-1);
        exp_q.push_back(w);
      end
      m_c = m_c + 1;
      if (m_c == W) begin
        m_c = 0;
        m_r = (m_r + 1) % H;
      end
      pix_cnt++;
    end
    @(posedge clk);
    #1;
    if (bus.out_valid) begin
      w = '{flat: bus.win_flat, row: bus.out_row, col: bus.out_col, fd: bus.frame_done};
      obs_q.push_back(w);
      obs_at.push_back(pix_cnt - 1);
      if (!v) stall_viol++;
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input logic sof_first, input logic stalls);
    for (int k = 0; k < W*H; k++) begin
      if (stalls && k > 0) repeat ($urandom_range(1, 3)) send(1'b0, DW'($urandom), 1'b0);
      send(1'b1, base + DW'(k << 8), sof_first && k == 0);
    end
  endtask

  function automatic int fd_count();
    int n = 0;
    foreach (obs_q[i]) if (obs_q[i].fd) n++;
    return n;
  endfunction

  task automatic test_reset();
    do_reset();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", bus.frame_done); end
    total++; if (bus.win_flat !== '0) begin bad++; $display("FAIL reset_win_flat got=%h want=0", bus.win_flat); end
    total++; if (bus.out_row !== 2'd0) begin bad++; $display("FAIL reset_out_row got=%0d want=0", bus.out_row); end
    total++; if (bus.out_col !== 2'd0) begin bad++; $display("FAIL reset_out_col got=%0d want=0", bus.out_col); end
  endtask

  task automatic test_single_frame();
    int exp_at[4] = '{10, 11, 14, 15};
    do_reset();
    send_frame(16'h0000, 1'b0, 1'b0);
    total++; if (obs_q.size() != 4) begin bad++; $display("FAIL single_count got=%0d want=4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      total++; if (obs_at[i] != exp_at[i]) begin bad++; $display("FAIL single_timing[%0d] got=%0d want=%0d", i, obs_at[i], exp_at[i]); end
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL single_win[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() == 4) begin
      total++; if (obs_q[0].flat[143:128] !== 16'h0000 || obs_q[0].flat[79:64] !== 16'h0500 || obs_q[0].flat[15:0] !== 16'h0A00)
        begin bad++; $display("FAIL single_first got=%h want w00=0000 w11=0500 w22=0A00", obs_q[0].flat); end
      total++; if (obs_q[3].flat[15:0] !== 16'h0F00 || obs_q[3].row !== 2'd1 || obs_q[3].col !== 2'd1 || obs_q[3].fd !== 1'b1)
        begin bad++; $display("FAIL single_last got=%h want w22=0F00 row=1 col=1 fd=1", obs_q[3]); end
    end
    total++; if (fd_count() != 1) begin bad++; $display("FAIL single_fd got=%0d want=1", fd_count()); end
  endtask

  task automatic test_stalls();
    do_reset();
    send_frame(16'h0000, 1'b0, 1'b1);
    total++; if (obs_q.size() != 4) begin bad++; $display("FAIL stall_count got=%0d want=4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_win[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (stall_viol != 0) begin bad++; $display("FAIL stall_valid_after_idle got=%0d want=0", stall_viol); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(16'h0000, 1'b0, 1'b0);
    send_frame(16'h1000, 1'b0, 1'b0);
    total++; if (obs_q.size() != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", obs_q.size()); end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_win[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (fd_count() != 2) begin bad++; $display("FAIL b2b_fd got=%0d want=2", fd_count()); end
    if (obs_q.size() > 4) begin
      total++; if (obs_q[4].flat[143:128] !== 16'h1000) begin bad++; $display("FAIL b2b_second_w00 got=%h want=1000", obs_q[4].flat[143:128]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int exp_at[4] = '{10, 11, 14, 15};
    do_reset();
    for (int k = 0; k < 10; k++) send(1'b1, DW'(16'h2000 + (k << 8)), 1'b0);
    do_reset();
    total++; if (bus.out_valid !== 1'b0 || bus.win_flat !== '0 || bus.out_row !== 2'd0 || bus.out_col !== 2'd0 || bus.frame_done !== 1'b0)
      begin bad++; $display("FAIL midrst_outputs got v=%b w=%h r=%0d c=%0d fd=%b want all 0", bus.out_valid, bus.win_flat, bus.out_row, bus.out_col, bus.frame_done); end
    send_frame(16'h0000, 1'b0, 1'b0);
    total++; if (obs_q.size() != 4) begin bad++; $display("FAIL midrst_count got=%0d want=4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      total++; if (obs_at[i] != exp_at[i]) begin bad++; $display("FAIL midrst_timing[%0d] got=%0d want=%0d", i, obs_at[i], exp_at[i]); end
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL midrst_win[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_frame_sync();
    do_reset();
    for (int k = 0; k < 6; k++) send(1'b1, DW'(16'h7700 + k), 1'b0);
    send_frame(16'h0000, 1'b1, 1'b0);
    total++; if (obs_q.size() != 4) begin bad++; $display("FAIL sync_count got=%0d want=4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL sync_win[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() > 0) begin
`ifdef WIN_FRAME_SYNC_EN
      total++; if (obs_at[0] != 16) begin bad++; $display("FAIL sync_first_at got=%0d want=16", obs_at[0]); end
      total++; if (obs_q[0].flat[15:0] !== 16'h0A00 || obs_q[0].flat[143:128] !== 16'h0000)
        begin bad++; $display("FAIL sync_first_win got=%h want w00=0000 w22=0A00", obs_q[0].flat); end
      total++; if (fd_count() != 1) begin bad++; $display("FAIL sync_fd got=%0d want=1", fd_count()); end
`else
      total++; if (obs_at[0] != 10) begin bad++; $display("FAIL nosync_first_at got=%0d want=10", obs_at[0]); end
      total++; if (obs_q[0].flat[15:0] !== 16'h0400) begin bad++; $display("FAIL nosync_first_w22 got=%h want=0400", obs_q[0].flat[15:0]); end
`endif
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 2*W*H; k++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) send(1'b0, DW'($urandom), 1'b0);
      send(1'b1, DW'($urandom), 1'b0);
    end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_win[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (stall_viol != 0) begin bad++; $display("FAIL rand_valid_after_idle got=%0d want=0", stall_viol); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sof   = 1'b0;
    test_reset();
    test_single_frame();
    test_stalls();
    test_back_to_back();
    test_reset_mid_frame();
    test_frame_sync();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
